// File: rtl/pixel_pkg.sv
// Shared widths, raster geometry and state encoding for the pixel combinator.
// Modules take these as parameter defaults so a bench can shrink the raster.
package pixel_pkg;
    localparam int DATA_WIDTH = 10;
    localparam int RBG_SIZE   = 24;
    localparam int X_SIZE     = 640;
    localparam int Y_SIZE     = 480;

    typedef logic [DATA_WIDTH-1:0] coord_t;
    typedef logic [RBG_SIZE-1:0]   colour_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} comb_state_t;
endpackage

// File: rtl/pixel_combinator_raster_cursor.sv
// Raster x/y cursor: steps through the frame one pixel per advance and wraps
// to (0,0) after the last pixel. The registers double as the check coordinate.
module raster_cursor
    import pixel_pkg::*;
#(
    parameter int DATA_WIDTH = pixel_pkg::DATA_WIDTH,
    parameter int X_SIZE     = pixel_pkg::X_SIZE,
    parameter int Y_SIZE     = pixel_pkg::Y_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  eol,
    output logic                  last_pixel
);

    assign eol        = (x == DATA_WIDTH'(X_SIZE - 1));
    assign last_pixel = eol && (y == DATA_WIDTH'(Y_SIZE - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (last_pixel) begin
                x <= '0;
                y <= '0;
            end else if (eol) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_combinator.sv
// Raster-order scheduler: broadcasts the cursor to the engine queues, pops the
// lowest-index matching queue and forwards its colour on a valid/ready stream.
module pixel_combinator
    import pixel_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int DATA_WIDTH  = pixel_pkg::DATA_WIDTH,
    parameter int RBG_SIZE    = pixel_pkg::RBG_SIZE,
    parameter int X_SIZE      = pixel_pkg::X_SIZE,
    parameter int Y_SIZE      = pixel_pkg::Y_SIZE,
    parameter int TIMEOUT     = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_ENGINES-1:0]          match_i,
    input  logic [NUM_ENGINES*RBG_SIZE-1:0] colour_i,
    output logic [DATA_WIDTH-1:0]           xpixel_check,
    output logic [DATA_WIDTH-1:0]           ypixel_check,
    output logic [NUM_ENGINES-1:0]          pop_o,
    output logic [RBG_SIZE-1:0]             out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_sof,
    output logic                            out_eol,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            stall_err,
    output logic                            dup_err
);

    localparam int SEL_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    comb_state_t        state, next_state;
    logic               take, any_match, multi_match, eol, last_pixel, drain_ok;
    logic [SEL_W-1:0]   sel;
    logic [RBG_SIZE-1:0] picked;
    logic [CNT_W-1:0]   stall_cnt;

    raster_cursor #(
        .DATA_WIDTH(DATA_WIDTH),
        .X_SIZE    (X_SIZE),
        .Y_SIZE    (Y_SIZE)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .advance   (take),
        .x         (xpixel_check),
        .y         (ypixel_check),
        .eol       (eol),
        .last_pixel(last_pixel)
    );

    // Descending scan leaves the lowest-index matching engine in sel.
    always_comb begin
        any_match   = |match_i;
        multi_match = ($countones(match_i) > 1);
        sel         = '0;
        for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
            if (match_i[k]) sel = SEL_W'(k);
        end
        picked = colour_i[int'(sel)*RBG_SIZE +: RBG_SIZE];
    end

    assign drain_ok = !out_valid || out_ready;

    always_comb begin
        next_state = state;
        take       = 1'b0;
        pop_o      = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                take = any_match && drain_ok;
                if (take) begin
                    pop_o[sel] = 1'b1;
                    if (last_pixel) next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_ok) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
        end else begin
            state      <= next_state;
            frame_done <= (state == DRAIN) && drain_ok;
            if (take) begin
                out_data  <= picked;
                out_sof   <= (xpixel_check == '0) && (ypixel_check == '0);
                out_eol   <= eol;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Only starvation (no match at all) counts toward the timeout; backpressure does not.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
            dup_err   <= 1'b0;
        end else begin
            if (state != RUN || take) begin
                stall_cnt <= '0;
            end else if (!any_match && stall_cnt != CNT_W'(TIMEOUT)) begin
                stall_cnt <= stall_cnt + 1'b1;
                if (stall_cnt == CNT_W'(TIMEOUT - 1)) stall_err <= 1'b1;
            end
            if (state == RUN && multi_match) dup_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_combinator.sv
// Directed bench for pixel_combinator on a 4x2 raster with two engines:
// plain frame, backpressure plus dual match, starvation, and mid-frame reset.
module tb_pixel_combinator;

    localparam int NE  = 2;
    localparam int DW  = 10;
    localparam int CW  = 24;
    localparam int XS  = 4;
    localparam int YS  = 2;
    localparam int TMO = 16;
    localparam int NPIX = XS * YS;

    logic              clk = 1'b0;
    logic              reset, start, out_ready;
    logic [NE-1:0]     match_i;
    logic [NE*CW-1:0]  colour_i;
    logic [DW-1:0]     xpixel_check, ypixel_check;
    logic [NE-1:0]     pop_o;
    logic [CW-1:0]     out_data;
    logic              out_valid, out_sof, out_eol, busy, frame_done, stall_err, dup_err;

    int total = 0;
    int bad   = 0;
    int frame_tag = 0;

    pixel_combinator #(
        .NUM_ENGINES(NE), .DATA_WIDTH(DW), .RBG_SIZE(CW),
        .X_SIZE(XS), .Y_SIZE(YS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .match_i(match_i), .colour_i(colour_i),
        .xpixel_check(xpixel_check), .ypixel_check(ypixel_check), .pop_o(pop_o),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eol(out_eol), .busy(busy), .frame_done(frame_done),
        .stall_err(stall_err), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] colour_of(input int p);
        return {8'(8'h10 + frame_tag), 8'(p), 8'(p * 3 + 1)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    // The matched slot carries the pixel colour; the other slot carries a decoy.
    task automatic applyStimulus(input logic [NE-1:0] m, input logic rdy, input int p);
        logic [CW-1:0] s0, s1;
        s0 = 24'hDEAD00 | 24'(p);
        s1 = 24'hBEEF00 | 24'(p);
        if (m[0]) s0 = colour_of(p);
        else if (m[1]) s1 = colour_of(p);
        match_i   = m;
        out_ready = rdy;
        colour_i  = {s1, s0};
        #2;
    endtask

    task automatic runFrame(input int dual_at, input int bp_at, input int starve_at, input int reset_at);
        logic [NE-1:0] mask;
        start = 1'b1;
        match_i = '0;
        clockEdge();
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("start_x", xpixel_check, 0);
        checkOutput("start_y", ypixel_check, 0);
        for (int p = 0; p < NPIX; p++) begin
            mask = NE'(1) << (p % 2);
            if (p == reset_at) begin
                applyStimulus(mask, 1'b1, p);
                reset = 1'b0;
                clockEdge();
                reset = 1'b1;
                match_i = '0;
                #1;
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_x", xpixel_check, 0);
                checkOutput("rst_y", ypixel_check, 0);
                checkOutput("rst_valid", out_valid, 0);
                checkOutput("rst_stall", stall_err, 0);
                checkOutput("rst_dup", dup_err, 0);
                return;
            end
            if (p == starve_at) begin
                applyStimulus('0, 1'b1, p);
                for (int i = 0; i < TMO - 1; i++) clockEdge();
                checkOutput("stall_early", stall_err, 0);
                clockEdge();
                checkOutput("stall_set", stall_err, 1);
                checkOutput("stall_x", xpixel_check, p % XS);
                checkOutput("stall_y", ypixel_check, p / XS);
            end
            if (p == bp_at) begin
                for (int i = 0; i < 3; i++) begin
                    applyStimulus(mask, 1'b0, p);
                    checkOutput("bp_pop", pop_o, 0);
                    checkOutput("bp_x", xpixel_check, p % XS);
                    clockEdge();
                    checkOutput("bp_valid", out_valid, 1);
                    checkOutput("bp_data", out_data, colour_of(p - 1));
                end
            end
            applyStimulus((p == dual_at) ? NE'(3) : mask, 1'b1, p);
            checkOutput("pix_x", xpixel_check, p % XS);
            checkOutput("pix_y", ypixel_check, p / XS);
            checkOutput("pix_pop", pop_o, (p == dual_at) ? 1 : mask);
            clockEdge();
            checkOutput("pix_valid", out_valid, 1);
            checkOutput("pix_data", out_data, colour_of(p));
            checkOutput("pix_sof", out_sof, (p == 0) ? 1 : 0);
            checkOutput("pix_eol", out_eol, (p % XS == XS - 1) ? 1 : 0);
            if (p == dual_at) checkOutput("dup_set", dup_err, 1);
        end
        applyStimulus('0, 1'b1, 0);
        checkOutput("drain_pop", pop_o, 0);
        checkOutput("drain_busy", busy, 1);
        checkOutput("drain_done_low", frame_done, 0);
        clockEdge();
        checkOutput("done_pulse", frame_done, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_valid", out_valid, 0);
        checkOutput("done_x", xpixel_check, 0);
        clockEdge();
        checkOutput("done_single", frame_done, 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        match_i = '0;
        colour_i = '0;
        clockEdge();
        clockEdge();
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pop", pop_o, 0);
        checkOutput("reset_data", out_data, 0);
        checkOutput("reset_sof_eol", {out_sof, out_eol}, 0);
        checkOutput("reset_flags", {frame_done, stall_err, dup_err}, 0);
        checkOutput("reset_xy", {xpixel_check, ypixel_check}, 0);
        reset = 1'b1;

        frame_tag = 1;
        runFrame(-1, -1, -1, -1);
        checkOutput("f1_dup_clear", dup_err, 0);

        frame_tag = 2;
        runFrame(1, 3, -1, -1);
        checkOutput("f2_dup_sticky", dup_err, 1);

        frame_tag = 3;
        runFrame(-1, -1, 5, -1);
        checkOutput("f3_stall_sticky", stall_err, 1);

        frame_tag = 4;
        runFrame(-1, -1, -1, 5);

        frame_tag = 5;
        runFrame(-1, -1, -1, -1);
        checkOutput("f5_flags", {stall_err, dup_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
